// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding, PC width,
// boot PC and the redirect-source selector with its priority function.
// The optional redirect counter is enabled by defining REDIRECT_CNT_EN.
package fetch_sequencer_pkg;

    localparam int PC_W = 12;
    localparam logic [PC_W-1:0] BOOT_PC = 12'h000;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_REDIRECT = 2'd2
    } fetch_state_e;

    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_JR   = 3'd1,
        SEL_JAL  = 3'd2,
        SEL_J    = 3'd3,
        SEL_BR   = 3'd4
    } redir_sel_e;

    // Fixed priority jr > jal > j > taken branch; nothing selected unless the
    // execute stage is valid.
    function automatic redir_sel_e pick_source(input logic ex_valid,
                                               input logic jr,
                                               input logic jal,
                                               input logic j,
                                               input logic br_tk);
        redir_sel_e sel;
        sel = SEL_NONE;
        if (ex_valid) begin
            if (jr)         sel = SEL_JR;
            else if (jal)   sel = SEL_JAL;
            else if (j)     sel = SEL_J;
            else if (br_tk) sel = SEL_BR;
        end
        return sel;
    endfunction

endpackage

// File: rtl/fetch_target_sel.sv
// Combinational redirect decision and target address selection for the
// fetch sequencer. Pure logic, no state.
module fetch_target_sel
    import fetch_sequencer_pkg::*;
(
    input  logic            ex_valid,
    input  logic            br,
    input  logic            br_taken,
    input  logic            j_sig,
    input  logic            jr_sig,
    input  logic            jal_sig,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [16:0]     imm,
    input  logic [26:0]     target,
    input  logic [31:0]     rd_val,
    output logic            redirect,
    output logic [PC_W-1:0] next_target
);

    redir_sel_e      sel;
    logic [PC_W-1:0] br_tgt;
    logic            unused_hi_bits;

    // The PC space is 12 bits, so the sign-extension bits of imm above bit 11
    // cannot change the modulo-4096 branch sum; only the low 12 bits are added.
    assign br_tgt = ex_pc + PC_W'(1) + imm[PC_W-1:0];

    // Upper field bits fall outside the PC space and are intentionally dropped.
    assign unused_hi_bits = ^{imm[16:PC_W], target[26:PC_W], rd_val[31:PC_W]};

    // Pick the highest-priority source and route its target.
    always_comb begin
        sel         = pick_source(ex_valid, jr_sig, jal_sig, j_sig, br & br_taken);
        redirect    = (sel != SEL_NONE);
        next_target = '0;
        case (sel)
            SEL_JR:        next_target = rd_val[PC_W-1:0];
            SEL_JAL, SEL_J: next_target = target[PC_W-1:0];
            SEL_BR:        next_target = br_tgt;
            default:       next_target = '0;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: BOOT/FETCH/REDIRECT FSM driving a one-entry
// instruction buffer toward decode, with jr/jal/j/branch redirects from the
// execute stage. Optional feature: define REDIRECT_CNT_EN to add the 16-bit
// saturating redirect_cnt output.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            ex_valid,
    input  logic            br,
    input  logic            j_sig,
    input  logic            jr_sig,
    input  logic            jal_sig,
    input  logic            br_taken,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [16:0]     imm,
    input  logic [26:0]     target,
    input  logic [31:0]     rd_val,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic            insn_valid,
    output logic [31:0]     insn_out,
    output logic [PC_W-1:0] insn_pc,
    output logic            flush,
    output logic [PC_W-1:0] link_pc
`ifdef REDIRECT_CNT_EN
    ,
    output logic [15:0]     redirect_cnt
`endif
);

    fetch_state_e    state_q;
    logic [PC_W-1:0] pc_q;
    logic            insn_valid_q;
    logic [31:0]     insn_out_q;
    logic [PC_W-1:0] insn_pc_q;

    logic            redirect_raw;
    logic [PC_W-1:0] target_d;
    logic            take_redirect;
    logic            accept;

    fetch_target_sel u_target_sel (
        .ex_valid    (ex_valid),
        .br          (br),
        .br_taken    (br_taken),
        .j_sig       (j_sig),
        .jr_sig      (jr_sig),
        .jal_sig     (jal_sig),
        .ex_pc       (ex_pc),
        .imm         (imm),
        .target      (target),
        .rd_val      (rd_val),
        .redirect    (redirect_raw),
        .next_target (target_d)
    );

    // Redirects are honoured once out of BOOT; flush stays low while reset is held.
    assign take_redirect = reset_n && (state_q != ST_BOOT) && redirect_raw;

    // Request whenever the buffer is empty or decode drains it this cycle.
    assign imem_req  = (state_q == ST_FETCH) && (!insn_valid_q || !stall);
    assign imem_addr = pc_q;

    // A redirect wins over a returning instruction in the same cycle.
    assign accept = imem_req && imem_ack && !take_redirect;

    assign flush      = take_redirect;
    assign link_pc    = ex_pc + PC_W'(1);
    assign insn_valid = insn_valid_q;
    assign insn_out   = insn_out_q;
    assign insn_pc    = insn_pc_q;

    // Sequencer FSM: PC, state and the one-entry output buffer.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ST_BOOT;
            pc_q         <= BOOT_PC;
            insn_valid_q <= 1'b0;
            insn_out_q   <= '0;
            insn_pc_q    <= '0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    // Any late ack from before reset is ignored here.
                    state_q <= ST_FETCH;
                end
                ST_FETCH, ST_REDIRECT: begin
                    if (take_redirect) begin
                        state_q      <= ST_REDIRECT;
                        pc_q         <= target_d;
                        insn_valid_q <= 1'b0;
                    end else begin
                        state_q <= ST_FETCH;
                        if (accept) begin
                            insn_out_q   <= imem_data;
                            insn_pc_q    <= pc_q;
                            insn_valid_q <= 1'b1;
                            pc_q         <= pc_q + PC_W'(1);
                        end else if (!stall) begin
                            insn_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_BOOT;
                end
            endcase
        end
    end

`ifdef REDIRECT_CNT_EN
    logic [15:0] redirect_cnt_q;

    // Saturating count of redirect cycles.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            redirect_cnt_q <= '0;
        end else if (take_redirect && (redirect_cnt_q != 16'hFFFF)) begin
            redirect_cnt_q <= redirect_cnt_q + 16'd1;
        end
    end

    assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random
// traffic, checked every cycle against a transaction-level reference model.
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset_n, stall, ex_valid, br, j_sig, jr_sig, jal_sig, br_taken;
    logic [11:0] ex_pc;
    logic [16:0] imm;
    logic [26:0] target;
    logic [31:0] rd_val;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        insn_valid;
    logic [31:0] insn_out;
    logic [11:0] insn_pc;
    logic        flush;
    logic [11:0] link_pc;
`ifdef REDIRECT_CNT_EN
    logic [15:0] redirect_cnt;
`endif

    always #5 clock = ~clock;

    fetch_sequencer dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .stall     (stall),
        .ex_valid  (ex_valid),
        .br        (br),
        .j_sig     (j_sig),
        .jr_sig    (jr_sig),
        .jal_sig   (jal_sig),
        .br_taken  (br_taken),
        .ex_pc     (ex_pc),
        .imm       (imm),
        .target    (target),
        .rd_val    (rd_val),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .insn_valid(insn_valid),
        .insn_out  (insn_out),
        .insn_pc   (insn_pc),
        .flush     (flush),
        .link_pc   (link_pc)
`ifdef REDIRECT_CNT_EN
        ,
        .redirect_cnt(redirect_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Instruction memory contents: a distinct word per address.
    function automatic logic [31:0] mem_word(input logic [11:0] a);
        return {8'hC3, a ^ 12'h5A5, a};
    endfunction

    // Reference model: mode 0=booting, 1=fetching, 2=redirect bubble.
    typedef struct {
        logic [31:0] insn;
        int          pc;
    } slot_t;

    bit    m_known = 1'b0;
    int    m_mode;
    int    m_pc;
    slot_t m_buf[$];
    int    m_cnt;

    task automatic model_reset();
        m_mode = 0;
        m_pc   = 0;
        m_buf.delete();
        m_cnt  = 0;
    endtask

    // One clock: supply memory data, check outputs, advance model, cross the edge.
    task automatic step();
        bit    redir;
        int    tgt;
        int    immv;
        bit    req_exp;
        slot_t s;
        #1;
        imem_data = mem_word(imem_addr);
        #1;
        redir   = 1'b0;
        tgt     = 0;
        req_exp = 1'b0;
        if (m_known) begin
            if (m_mode != 0 && reset_n && ex_valid) begin
                immv = $signed(imm);
                if (jr_sig)                begin redir = 1'b1; tgt = int'(rd_val % 32'd4096); end
                else if (jal_sig || j_sig) begin redir = 1'b1; tgt = int'(target % 27'd4096); end
                else if (br && br_taken)   begin redir = 1'b1; tgt = ((int'(ex_pc) + 1 + immv) % 4096 + 4096) % 4096; end
            end
            req_exp = (m_mode == 1) && (m_buf.size() == 0 || !stall);
            check_eq("imem_req", 32'(imem_req), 32'(req_exp));
            check_eq("imem_addr", 32'(imem_addr), m_pc);
            check_eq("flush", 32'(flush), 32'(redir));
            check_eq("link_pc", 32'(link_pc), (int'(ex_pc) + 1) % 4096);
            check_eq("insn_valid", 32'(insn_valid), 32'(m_buf.size() != 0));
            if (m_buf.size() != 0) begin
                check_eq("insn_out", insn_out, m_buf[0].insn);
                check_eq("insn_pc", 32'(insn_pc), m_buf[0].pc);
            end
`ifdef REDIRECT_CNT_EN
            check_eq("redirect_cnt", 32'(redirect_cnt), m_cnt);
`endif
        end
        if (!reset_n) begin
            model_reset();
            m_known = 1'b1;
        end else if (m_known) begin
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (redir) begin
                m_buf.delete();
                m_pc   = tgt;
                m_mode = 2;
                if (m_cnt < 65535) m_cnt++;
            end else begin
                if (!stall && m_buf.size() != 0) void'(m_buf.pop_front());
                if (req_exp && imem_ack) begin
                    s.insn = imem_data;
                    s.pc   = m_pc;
                    m_buf.push_back(s);
                    m_pc = (m_pc + 1) % 4096;
                end
                m_mode = 1;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic quiet_ex();
        ex_valid = 0; br = 0; br_taken = 0; j_sig = 0; jr_sig = 0; jal_sig = 0;
    endtask

    initial begin
        int          first_v;
        logic [31:0] held;
        logic [11:0] held_pc;
        logic [11:0] a;

        reset_n = 0; stall = 0; imem_ack = 1; imem_data = '0;
        ex_pc = '0; imm = '0; target = '0; rd_val = '0;
        quiet_ex();

        // Reset and boot sequence with acks every cycle.
        step();
        step();
        check_eq("rst_valid", 32'(insn_valid), 0);
        check_eq("rst_insn_out", insn_out, 0);
        check_eq("rst_insn_pc", 32'(insn_pc), 0);
        check_eq("rst_req", 32'(imem_req), 0);
        check_eq("rst_flush", 32'(flush), 0);
        check_eq("rst_addr", 32'(imem_addr), 0);
        reset_n  = 1;
        first_v  = -1;
        for (int k = 0; k < 8; k++) begin
            if (insn_valid && first_v < 0) first_v = k;
            if (k >= 2) check_eq("seq_pc", 32'(insn_pc), k - 2);
            step();
        end
        check_eq("first_valid_cycle", first_v, 2);

        // Taken branch backwards: ex_pc 0x010 + 1 - 2 = 0x00F.
        ex_valid = 1; br = 1; br_taken = 1; ex_pc = 12'h010; imm = 17'h1FFFE;
        #1;
        check_eq("br_flush", 32'(flush), 1);
        step();
        quiet_ex();
        #1;
        check_eq("br_addr", 32'(imem_addr), 32'h00F);
        check_eq("br_bubble_req", 32'(imem_req), 0);
        check_eq("br_flush_once", 32'(flush), 0);
        check_eq("br_valid_clr", 32'(insn_valid), 0);
        step();
        check_eq("br_resume_req", 32'(imem_req), 1);

        // jr beats j.
        ex_valid = 1; jr_sig = 1; j_sig = 1; rd_val = 32'h0000_0ABC; target = 27'h123;
        step();
        quiet_ex();
        #1;
        check_eq("jr_prio_addr", 32'(imem_addr), 32'hABC);

        // Fill the buffer, then stall for 4 cycles with acks pending.
        step();
        step();
        stall   = 1;
        held    = insn_out;
        held_pc = insn_pc;
        #1;
        for (int i = 0; i < 4; i++) begin
            check_eq("stall_insn_out", insn_out, held);
            check_eq("stall_req", 32'(imem_req), 0);
            step();
        end
        stall = 0;
        step();
        check_eq("stall_release_pc", 32'(insn_pc), 32'(held_pc + 12'd1));
        check_eq("stall_release_insn", insn_out, mem_word(held_pc + 12'd1));

        // Jump to 0xFFF and wrap; jal link at 0xFFF.
        ex_valid = 1; j_sig = 1; target = 27'h0000FFF; ex_pc = 12'hFFF;
        #1;
        check_eq("link_wrap", 32'(link_pc), 0);
        step();
        quiet_ex();
        step();
        step();
        check_eq("wrap_insn_pc", 32'(insn_pc), 32'hFFF);
        check_eq("wrap_addr", 32'(imem_addr), 0);
        ex_valid = 1; jal_sig = 1; target = 27'h0000555; ex_pc = 12'hFFF;
        #1;
        check_eq("jal_link", 32'(link_pc), 0);
        step();
        quiet_ex();
        #1;
        check_eq("jal_addr", 32'(imem_addr), 32'h555);

        // Branch not taken: no flush, no PC change.
        step();
        imem_ack = 0;
        a = imem_addr;
        ex_valid = 1; br = 1; br_taken = 0; imm = 17'h00040;
        #1;
        check_eq("br_nt_flush", 32'(flush), 0);
        step();
        quiet_ex();
        check_eq("br_nt_pc", 32'(imem_addr), 32'(a));

        // Reset mid-fetch with an ack pending, then a late ack during BOOT.
        imem_ack = 1;
        reset_n  = 0;
        step();
        reset_n = 1;
        check_eq("boot_valid", 32'(insn_valid), 0);
        check_eq("boot_req", 32'(imem_req), 0);
        step();
        check_eq("boot_ack_ignored", 32'(insn_valid), 0);

`ifdef REDIRECT_CNT_EN
        // Three taken redirects after reset.
        reset_n = 0;
        step();
        reset_n = 1;
        step();
        for (int i = 0; i < 3; i++) begin
            ex_valid = 1; j_sig = 1; target = 27'(i * 16);
            step();
            quiet_ex();
            step();
        end
        check_eq("cnt_three", 32'(redirect_cnt), 3);
        // Preload near the top and push past saturation.
        dut.redirect_cnt_q = 16'hFFFD;
        m_cnt = 65533;
        for (int i = 0; i < 4; i++) begin
            ex_valid = 1; jr_sig = 1; rd_val = 32'(i);
            step();
        end
        quiet_ex();
        step();
        check_eq("cnt_saturate", 32'(redirect_cnt), 32'hFFFF);
`endif

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            reset_n  = ($urandom_range(0, 199) != 0);
            stall    = ($urandom_range(0, 9) < 3);
            imem_ack = ($urandom_range(0, 9) < 7);
            ex_valid = ($urandom_range(0, 9) < 2);
            br       = 1'($urandom);
            br_taken = 1'($urandom);
            j_sig    = ($urandom_range(0, 3) == 0);
            jr_sig   = ($urandom_range(0, 3) == 0);
            jal_sig  = ($urandom_range(0, 3) == 0);
            ex_pc    = 12'($urandom);
            imm      = 17'($urandom);
            target   = 27'($urandom);
            rd_val   = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have these ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- stall  in  1  decode/hazard hold; no new instruction accepted downstream
- ex_valid  in  1  execute-stage control signals below are valid this cycle
- br, j_sig, jr_sig, jal_sig  in  1 each  decoded control from execute stage
- br_taken  in  1  branch condition result (bne/blt/bex) from ALU
- ex_pc  in  12  PC of the execute-stage instruction
- imm  in  17  I-type immediate, two's complement
- target  in  27  JI-type target field
- rd_val  in  32  register value for jr
- imem_req  out  1  instruction memory read request
- imem_addr  out  12  instruction memory word address
- imem_ack  in  1  instruction data valid
- imem_data  in  32  instruction word
- insn_valid  out  1  insn_out holds a live instruction
- insn_out  out  32  instruction to decode
- insn_pc  out  12  PC of insn_out
- flush  out  1  one-cycle squash of younger in-flight instructions
- link_pc  out  12  ex_pc+1, return address for jal write to $31

Function
REQ-002 The FSM SHALL have three states: BOOT, FETCH, REDIRECT.
REQ-003 BOOT SHALL last exactly one cycle after reset release, drive imem_req=0, then go to FETCH.
REQ-004 In FETCH, imem_req SHALL be 1 whenever the 1-entry output buffer is empty or being drained this cycle; imem_addr SHALL equal the current pc.
REQ-005 On imem_ack in FETCH, the block SHALL load insn_out/insn_pc, set insn_valid next cycle and increment pc by 1, modulo 2^12 (0xFFF wraps to 0x000).
REQ-006 While stall=1, insn_out, insn_pc and insn_valid SHALL hold, and no new request SHALL issue once the buffer is full.
REQ-007 A redirect SHALL occur when ex_valid=1 and any of jr_sig, jal_sig, j_sig, or (br and br_taken) is set.
REQ-008 The redirect target SHALL be:
- jr: rd_val[11:0]
- jal, j: target[11:0]
- br: (ex_pc + 1 + sign-extended imm) truncated to 12 bits
REQ-009 If several redirect sources assert together, priority SHALL be jr > jal > j > br.
REQ-010 A redirect SHALL override stall and any pending imem_ack.
REQ-011 On a redirect, flush SHALL be 1 for exactly that cycle; insn_valid SHALL clear next cycle; pc SHALL load the target; the FSM SHALL enter REDIRECT.
REQ-012 REDIRECT SHALL last one cycle with imem_req=0; an imem_ack arriving in REDIRECT SHALL be discarded; then the FSM returns to FETCH.
REQ-013 link_pc SHALL be combinational ex_pc+1 modulo 2^12.
REQ-014 br with br_taken=0 SHALL cause no flush and no pc change.

Reset
REQ-015 When reset_n=0 at a rising edge, the block SHALL set:
- state=BOOT, pc=0x000
- insn_valid=0, insn_out=0, insn_pc=0
- flush=0, imem_req=0
REQ-016 Reset asserted mid-fetch SHALL abandon the outstanding request; a late imem_ack during BOOT SHALL be ignored.

Configuration
REQ-017 With REDIRECT_CNT_EN defined, the block SHALL add output redirect_cnt (16 bits, reset 0). The counter SHALL increment once per redirect cycle and saturate at 0xFFFF.
REQ-018 Without REDIRECT_CNT_EN, the redirect_cnt port and counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-019 A shared package SHALL hold:
- the FSM state encoding
- PC width (12)
- BOOT_PC (0x000)
- redirect priority selector encodings
REQ-020 Target computation SHALL live in one combinational sub-module, fetch_target_sel, that takes the control, ex_pc, imm, target and rd_val, and returns redirect and next_target.

Verification
REQ-021 Reset, then imem_ack every cycle with stall=0: insn_pc SHALL step 0,1,2,...; insn_valid SHALL first be 1 on the third cycle after release.
REQ-022 ex_pc=0x010, br=1, br_taken=1, imm=0x1FFFE (-2): flush=1 for 1 cycle, next imem_addr=0x00F, one REDIRECT bubble.
REQ-023 jr_sig=1 and j_sig=1 together, rd_val=0x0000_0ABC, target=0x123: pc SHALL become 0xABC.
REQ-024 stall=1 for 4 cycles with imem_ack pending: insn_out SHALL be unchanged, imem_req=0 once the buffer is full, and no instruction is lost on release.
REQ-025 pc=0xFFF fetch SHALL be followed by imem_addr=0x000; jal at ex_pc=0xFFF SHALL give link_pc=0x000.
REQ-026 With REDIRECT_CNT_EN, 3 taken redirects SHALL give redirect_cnt=3; a preload near 0xFFFF SHALL saturate the counter.
